// File: rtl/bm_awgn_pkg.sv
// Shared constants for the Box-Muller AWGN front end: the taus88 recurrence
// constants, the minimum-value seed fixes and the seed word select encodings.
package bm_awgn_pkg;

    localparam logic [31:0] TausMask1 = 32'hFFFF_FFFE;
    localparam logic [31:0] TausMask2 = 32'hFFFF_FFF8;
    localparam logic [31:0] TausMask3 = 32'hFFFF_FFF0;

    // Shift amounts per component: masked left shift, feedback left shift, feedback right shift
    localparam int unsigned TausK1 = 12;
    localparam int unsigned TausQ1 = 13;
    localparam int unsigned TausS1 = 19;
    localparam int unsigned TausK2 = 4;
    localparam int unsigned TausQ2 = 2;
    localparam int unsigned TausS2 = 25;
    localparam int unsigned TausK3 = 17;
    localparam int unsigned TausQ3 = 3;
    localparam int unsigned TausS3 = 11;

    localparam logic [31:0] MinFix1 = 32'h0000_0002;
    localparam logic [31:0] MinFix2 = 32'h0000_0008;
    localparam logic [31:0] MinFix3 = 32'h0000_0010;

    typedef enum logic [2:0] {
        SelA1   = 3'd0,
        SelA2   = 3'd1,
        SelA3   = 3'd2,
        SelB1   = 3'd3,
        SelB2   = 3'd4,
        SelB3   = 3'd5,
        SelNop6 = 3'd6,
        SelNop7 = 3'd7
    } seed_sel_e;

    function automatic logic [31:0] taus_comp(input logic [31:0] s, input logic [31:0] mask,
                                              input int unsigned k, input int unsigned q,
                                              input int unsigned r);
        return ((s & mask) << k) ^ (((s << q) ^ s) >> r);
    endfunction

endpackage

// File: rtl/taus88_core.sv
// One taus88 generator: three state words, seed load port and a step enable.
// word_o is the output word of the step that would be taken this cycle.
module taus88_core
    import bm_awgn_pkg::*;
#(
    parameter logic [31:0] SEED1 = 32'h1234_5678,
    parameter logic [31:0] SEED2 = 32'h9ABC_DEF0,
    parameter logic [31:0] SEED3 = 32'h0F1E_2D3C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_i,
    input  logic        load_i,
    input  logic [1:0]  load_idx_i,
    input  logic [31:0] load_data_i,
    output logic [31:0] word_o
);

    logic [31:0] s1_q, s2_q, s3_q;
    logic [31:0] s1_d, s2_d, s3_d;
    logic [31:0] s1_n, s2_n, s3_n;

    assign s1_n   = taus_comp(s1_q, TausMask1, TausK1, TausQ1, TausS1);
    assign s2_n   = taus_comp(s2_q, TausMask2, TausK2, TausQ2, TausS2);
    assign s3_n   = taus_comp(s3_q, TausMask3, TausK3, TausQ3, TausS3);
    assign word_o = s1_n ^ s2_n ^ s3_n;

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (load_i) begin
            case (load_idx_i)
                2'd0:    s1_d = load_data_i | MinFix1;
                2'd1:    s2_d = load_data_i | MinFix2;
                2'd2:    s3_d = load_data_i | MinFix3;
                default: ;
            endcase
        end else if (step_i) begin
            s1_d = s1_n;
            s2_d = s2_n;
            s3_d = s3_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= SEED1 | MinFix1;
            s2_q <= SEED2 | MinFix2;
            s3_q <= SEED3 | MinFix3;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: rtl/taus_urng48.sv
// Dual taus88 uniform source: 48-bit u0 for the LZD/log path and 16-bit u1
// for the sin/cos path, with a single-entry valid/ready output register.
module taus_urng48
    import bm_awgn_pkg::*;
#(
    parameter logic [31:0] SEED_A1 = 32'h1234_5678,
    parameter logic [31:0] SEED_A2 = 32'h9ABC_DEF0,
    parameter logic [31:0] SEED_A3 = 32'h0F1E_2D3C,
    parameter logic [31:0] SEED_B1 = 32'h8765_4321,
    parameter logic [31:0] SEED_B2 = 32'h1357_9BDF,
    parameter logic [31:0] SEED_B3 = 32'h2468_ACE0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        seed_we,
    input  logic [2:0]  seed_sel,
    input  logic [31:0] seed_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [47:0] u0,
    output logic [15:0] u1,
    output logic [31:0] sample_cnt
);

    logic        valid_q, valid_d;
    logic [47:0] u0_q, u0_d;
    logic [15:0] u1_q, u1_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fire;
    logic        load_a, load_b;
    logic [1:0]  idx_a, idx_b;
    logic [31:0] word_a, word_b;
    seed_sel_e   sel;

    assign sel  = seed_sel_e'(seed_sel);
    assign fire = en & ~seed_we & (~valid_q | out_ready);

    always_comb begin
        load_a = 1'b0;
        load_b = 1'b0;
        idx_a  = 2'd0;
        idx_b  = 2'd0;
        case (sel)
            SelA1: begin load_a = seed_we; idx_a = 2'd0; end
            SelA2: begin load_a = seed_we; idx_a = 2'd1; end
            SelA3: begin load_a = seed_we; idx_a = 2'd2; end
            SelB1: begin load_b = seed_we; idx_b = 2'd0; end
            SelB2: begin load_b = seed_we; idx_b = 2'd1; end
            SelB3: begin load_b = seed_we; idx_b = 2'd2; end
            default: ;
        endcase
    end

    taus88_core #(
        .SEED1(SEED_A1),
        .SEED2(SEED_A2),
        .SEED3(SEED_A3)
    ) u_gen_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (fire),
        .load_i     (load_a),
        .load_idx_i (idx_a),
        .load_data_i(seed_data),
        .word_o     (word_a)
    );

    taus88_core #(
        .SEED1(SEED_B1),
        .SEED2(SEED_B2),
        .SEED3(SEED_B3)
    ) u_gen_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (fire),
        .load_i     (load_b),
        .load_idx_i (idx_b),
        .load_data_i(seed_data),
        .word_o     (word_b)
    );

    always_comb begin
        valid_d = valid_q;
        u0_d    = u0_q;
        u1_d    = u1_q;
        // A seed write still counts a handshake that happens in the same cycle
        cnt_d   = (valid_q & out_ready) ? cnt_q + 32'd1 : cnt_q;
        if (seed_we) begin
            valid_d = 1'b0;
        end else if (fire) begin
            valid_d = 1'b1;
            u0_d    = {word_a, word_b[31:16]};
            u1_d    = word_b[15:0];
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            u0_q    <= 48'd0;
            u1_q    <= 16'd0;
            cnt_q   <= 32'd0;
        end else begin
            valid_q <= valid_d;
            u0_q    <= u0_d;
            u1_q    <= u1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign u0         = u0_q;
    assign u1         = u1_q;
    assign sample_cnt = cnt_q;

endmodule

// File: doc/taus_urng48.md
TAUS_URNG48 -- requirements
Module: taus_urng48

Interface
REQ-001 SHALL have parameter SEED_A1, default 32'h1234_5678, meaning generator A component-1 reset seed.
REQ-002 SHALL have parameters SEED_A2/SEED_A3/SEED_B1/SEED_B2/SEED_B3, defaults 32'h9ABC_DEF0/32'h0F1E_2D3C/32'h8765_4321/32'h1357_9BDF/32'h2468_ACE0, meaning the remaining reset seeds.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, generation enable.
REQ-006 SHALL have port seed_we, input, 1, seed word write strobe.
REQ-007 SHALL have port seed_sel, input, 3, seed word select: 0-2 = A s1..s3, 3-5 = B s1..s3, 6-7 = no effect.
REQ-008 SHALL have port seed_data, input, 32, seed word value.
REQ-009 SHALL have port out_ready, input, 1, downstream (48-bit LZD / log stage) accepts the sample.
REQ-010 SHALL have port out_valid, output, 1, u0/u1 hold a valid sample.
REQ-011 SHALL have port u0, output, 48, uniform sample feeding the leading-zero detector and log path.
REQ-012 SHALL have port u1, output, 16, uniform sample feeding the sin/cos path.
REQ-013 SHALL have port sample_cnt, output, 32, count of accepted samples.

Function
REQ-014 SHALL contain two identical taus88 generators A and B, each with three 32-bit state words s1, s2, s3.
REQ-015 SHALL compute each step as follows: s1' = ((s1 & FFFFFFFE)<<12) ^ (((s1<<13)^s1)>>19); s2' = ((s2 & FFFFFFF8)<<4) ^ (((s2<<2)^s2)>>25); s3' = ((s3 & FFFFFFF0)<<17) ^ (((s3<<3)^s3)>>11); word = s1'^s2'^s3'. All operations are 32-bit logical with truncation.
REQ-016 SHALL define fire = en & ~seed_we & (~out_valid | out_ready).
REQ-017 SHALL, on fire, advance both generators one step, load u0 = {wordA[31:0], wordB[31:16]} and u1 = wordB[15:0], and set out_valid=1 on the next edge (latency 1 cycle).
REQ-018 SHALL, when out_valid & out_ready & ~fire, clear out_valid and keep u0/u1.
REQ-019 SHALL, when out_valid & ~out_ready, hold u0, u1, out_valid and all state stable; en has no effect.
REQ-020 SHALL increment sample_cnt on each out_valid & out_ready cycle, wrapping FFFFFFFF->0.
REQ-021 SHALL, on seed_we with seed_sel 0-5, store the word with a minimum-value fix: s1 word |= 32'h2, s2 word |= 32'h8, s3 word |= 32'h10.
REQ-022 SHALL, on seed_we with any seed_sel, suppress fire for that cycle, clear out_valid next edge, and leave sample_cnt unchanged; a pending sample is discarded.
REQ-023 SHALL treat seed_we and out_ready in the same cycle as follows: the seed write wins, out_valid clears, and the count still increments if out_valid was 1.
REQ-024 SHALL ignore seed_we with seed_sel 6-7 for state, but still apply the REQ-022 effects.

Reset
REQ-025 SHALL, on rst_n low, immediately set: out_valid=0, u0=0, u1=0, sample_cnt=0, state words = seed parameters each with the REQ-021 fix applied.
REQ-026 SHALL, when reset asserts mid-stream, discard any pending sample; the first sample after release is the first sample of the seed sequence.

Structure
REQ-027 SHALL place the taus88 masks, shift amounts, minimum-fix constants and seed_sel encodings in shared package bm_awgn_pkg.
REQ-028 SHALL implement one generator as sub-module taus88_core (state registers, seed load port, step enable, 32-bit word output), instantiated twice.

Verification
REQ-029 SHALL cover: seed_we all six words = 0, then en=1, out_ready=1 -> first u0 = 48'h0020_2080_0020, u1 = 16'h2080, out_valid one cycle after en.
REQ-030 SHALL cover: reset then en=1, out_ready=1 for 1000 cycles -> u0/u1 match a C taus88 model per sample; sample_cnt = 999 or 1000 per latency.
REQ-031 SHALL cover: out_ready=0 for 5 cycles while out_valid=1 -> u0/u1/sample_cnt constant; after release, the next sample is the model's next one (none skipped).
REQ-032 SHALL cover: seed_we with seed_sel=0, data=1 -> stored A s1 = 32'h3; with seed_sel=7 -> state unchanged, out_valid cleared.
REQ-033 SHALL cover: rst_n pulsed low mid-stream asynchronously (between edges) -> outputs 0 immediately; the post-release sequence equals the post-power-on sequence.
REQ-034 SHALL cover: seed_we coinciding with out_valid & out_ready -> sample_cnt increments, out_valid=0 next cycle, no state advance.
